// File: rtl/truth_table_sweeper.sv
// Self-check harness: sweeps every stim vector into a small gate block and compares resp to EXPECTED.
// Optional build macro TTS_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
    parameter int                    N_IN     = 3,
    parameter int                    SETTLE   = 1,
    parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'h0A
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int               CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  STIM_LAST = {N_IN{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [N_IN:0]    err_count_q, err_count_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic             first_fail_vld_q, first_fail_vld_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch_s;

    function automatic logic expected_bit(input logic [N_IN-1:0] vec);
        return EXPECTED[vec];
    endfunction

    // Compare the sampled response against the truth table entry for the current vector
    always_comb begin
        mismatch_s = resp ^ expected_bit(stim_q);
    end

    // Next-state and datapath updates for the sweep FSM
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        stim_d           = stim_q;
        err_count_d      = err_count_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;
        pass_d           = pass_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stim_d           = {N_IN{1'b0}};
                    cnt_d            = {CNT_W{1'b0}};
                    err_count_d      = {(N_IN+1){1'b0}};
                    first_fail_d     = {N_IN{1'b0}};
                    first_fail_vld_d = 1'b0;
                    pass_d           = 1'b0;
                    busy_d           = 1'b1;
                    state_d          = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    err_count_d = err_count_q + (N_IN+1)'(1);
                    if (!first_fail_vld_q) begin
                        first_fail_d     = stim_q;
                        first_fail_vld_d = 1'b1;
                    end else begin
                        first_fail_d     = first_fail_q;
                        first_fail_vld_d = first_fail_vld_q;
                    end
                end else begin
                    err_count_d = err_count_q;
                end
`ifdef TTS_STOP_ON_FAIL_EN
                if (mismatch_s || (stim_q == STIM_LAST)) begin
`else
                if (stim_q == STIM_LAST) begin
`endif
                    // pass is resolved on entry to FIN so it is already valid alongside done
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == {(N_IN+1){1'b0}});
                end else begin
                    stim_d  = stim_q + N_IN'(1);
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_WAIT;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= {CNT_W{1'b0}};
            stim_q           <= {N_IN{1'b0}};
            err_count_q      <= {(N_IN+1){1'b0}};
            first_fail_q     <= {N_IN{1'b0}};
            first_fail_vld_q <= 1'b0;
            pass_q           <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            stim_q           <= stim_d;
            err_count_q      <= err_count_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
            pass_q           <= pass_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: expected sweep results are queued at start, checked on done.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [1:0] mode = 2'd0;
    logic [1:0] sel = 2'd0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_mis = 0;
    int         n_done = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] stim_1, stim_3, stim_2, ff_1, ff_3, ff_2;
    logic [3:0] err_1, err_3, err_2;
    logic       busy_1, busy_3, busy_2, done_1, done_3, done_2;
    logic       pass_1, pass_3, pass_2, ffv_1, ffv_3, ffv_2;
    logic       resp_1, resp_3, resp_2;
    logic [2:0] pipe_3, pipe_2;

    // Hand-written gate model: output 1 only for inputs 1 and 3
    function automatic logic ref_f(input logic [2:0] v);
        return (v == 3'd1) || (v == 3'd3);
    endfunction

    always_comb begin
        case (mode)
            2'd1:    resp_1 = 1'b0;
            2'd2:    resp_1 = 1'b1;
            default: resp_1 = ref_f(stim_1);
        endcase
    end

    // Three register stages of delay in front of the slower instances
    always @(posedge clk) begin
        if (rst) begin
            pipe_3 <= 3'b000;
            pipe_2 <= 3'b000;
        end else begin
            pipe_3 <= {pipe_3[1:0], ref_f(stim_3)};
            pipe_2 <= {pipe_2[1:0], ref_f(stim_2)};
        end
    end
    assign resp_3 = pipe_3[2];
    assign resp_2 = pipe_2[2];

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h0A)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .resp(resp_1), .stim(stim_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .err_count(err_1),
        .first_fail(ff_1), .first_fail_vld(ffv_1));

    truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECTED(8'h0A)) u_d3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .resp(resp_3), .stim(stim_3),
        .busy(busy_3), .done(done_3), .pass(pass_3), .err_count(err_3),
        .first_fail(ff_3), .first_fail_vld(ffv_3));

    truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(8'h0A)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .resp(resp_2), .stim(stim_2),
        .busy(busy_2), .done(done_2), .pass(pass_2), .err_count(err_2),
        .first_fail(ff_2), .first_fail_vld(ffv_2));

    logic [2:0] m_stim, m_ff;
    logic [3:0] m_err;
    logic       m_busy, m_done, m_pass, m_ffv;

    always_comb begin
        case (sel)
            2'd1:    begin m_stim = stim_3; m_ff = ff_3; m_err = err_3; m_busy = busy_3; m_done = done_3; m_pass = pass_3; m_ffv = ffv_3; end
            2'd2:    begin m_stim = stim_2; m_ff = ff_2; m_err = err_2; m_busy = busy_2; m_done = done_2; m_pass = pass_2; m_ffv = ffv_2; end
            default: begin m_stim = stim_1; m_ff = ff_1; m_err = err_1; m_busy = busy_1; m_done = done_1; m_pass = pass_1; m_ffv = ffv_1; end
        endcase
    end

    typedef struct {
        int         done_cyc;
        logic [3:0] err;
        logic [2:0] ff;
        logic       ffv;
        logic       pass;
        logic [2:0] stim;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int dc, input int err, input int ff, input int ffv,
                            input int pss, input int stm);
        exp_t e;
        e.done_cyc = dc;
        e.err      = 4'(err);
        e.ff       = 3'(ff);
        e.ffv      = 1'(ffv);
        e.pass     = 1'(pss);
        e.stim     = 3'(stm);
        exp_q.push_back(e);
    endtask

    // Monitor: on each done pulse pop the oldest expectation, check timing, then the held results
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", int'(m_done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    @(negedge clk);
                    chk("done_width", int'(m_done), 0);
                    chk("busy_after_done", int'(m_busy), 0);
                    chk("err_count", int'(m_err), int'(e.err));
                    chk("first_fail_vld", int'(m_ffv), int'(e.ffv));
                    chk("first_fail", int'(m_ff), int'(e.ff));
                    chk("pass", int'(m_pass), int'(e.pass));
                    chk("stim_final", int'(m_stim), int'(e.stim));
                    n_done++;
                end
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && n_done < target; i++) @(negedge clk);
        chk("sweep_complete", n_done, target);
    endtask

    // One start pulse on instance s; latency is the done cycle counted from the sampling edge
    task automatic run_sweep(input int s, input int md, input int lat, input int err,
                             input int ff, input int ffv, input int pss, input int stm);
        int st_edge;
        int target;
        sel  = 2'(s);
        mode = 2'(md);
        @(negedge clk);
        chk("busy_idle", int'(m_busy), 0);
        start_v[s] = 1'b1;
        st_edge = cyc + 1;
        target  = n_done + 1;
        push_exp(st_edge + lat - 1, err, ff, ffv, pss, stm);
        @(negedge clk);
        start_v[s] = 1'b0;
        chk("busy_after_start", int'(m_busy), 1);
        wait_done(target);
    endtask

    initial begin
        int st_edge;
        int target;
        repeat (3) @(negedge clk);
        chk("rst_stim", int'(stim_1), 0);
        chk("rst_busy", int'(busy_1), 0);
        chk("rst_pass", int'(pass_1), 0);
        chk("rst_err", int'(err_1), 0);
        rst = 1'b0;

        // correct model, tied 0, tied 1
        run_sweep(0, 0, 17, 0, 0, 0, 1, 7);
`ifdef TTS_STOP_ON_FAIL_EN
        run_sweep(0, 1, 5, 1, 1, 1, 0, 1);
        run_sweep(0, 2, 3, 1, 0, 1, 0, 0);
`else
        run_sweep(0, 1, 17, 2, 1, 1, 0, 7);
        run_sweep(0, 2, 17, 6, 0, 1, 0, 7);
`endif
        // three-stage delayed model: SETTLE=3 passes, SETTLE=2 sees the previous vector
        run_sweep(1, 0, 33, 0, 0, 0, 1, 7);
`ifdef TTS_STOP_ON_FAIL_EN
        run_sweep(2, 0, 7, 1, 1, 1, 0, 1);
`else
        run_sweep(2, 0, 25, 4, 1, 1, 0, 7);
`endif

        // start held high: one sweep per IDLE acceptance, second begins right after FIN
        sel  = 2'd0;
        mode = 2'd0;
        @(negedge clk);
        start_v[0] = 1'b1;
        st_edge = cyc + 1;
        target  = n_done + 2;
        push_exp(st_edge + 16, 0, 0, 0, 1, 7);
        push_exp(st_edge + 34, 0, 0, 0, 1, 7);
        repeat (20) @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(target);

        // reset in the middle of a sweep aborts it silently
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int i = 0; i < 100 && stim_1 != 3'd4; i++) @(negedge clk);
        chk("reached_stim4", int'(stim_1), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_stim", int'(stim_1), 0);
        chk("abort_busy", int'(busy_1), 0);
        chk("abort_done", int'(done_1), 0);
        chk("abort_err", int'(err_1), 0);
        chk("abort_ffv", int'(ffv_1), 0);
        chk("abort_ff", int'(ff_1), 0);
        chk("abort_pass", int'(pass_1), 0);
        repeat (20) @(negedge clk);
        run_sweep(0, 0, 17, 0, 0, 0, 1, 7);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
